// File: rtl/sincos_phase_gen.sv
// Phase-accumulator NCO feeding the sin/cos block; optional IQ pairing under SINCOS_PHASE_IQ_EN.
// Latency: first sample valid one cycle after the edge following the start edge; registered outputs.
// Backpressure: hold_i stalls emission (acc/count frozen); stop_i aborts to IDLE without done_o.
module sincos_phase_gen #(
    parameter int PHASE_W = 47,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               hold_i,
    input  logic [PHASE_W-1:0] freq_word_i,
    input  logic [PHASE_W-1:0] phase_ofs_i,
    input  logic [CNT_W-1:0]   burst_len_i,
    input  logic               mode_cos_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic               mode_cos_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               counted_q, counted_d;
    logic               cos_beat_q, cos_beat_d;
    logic [PHASE_W-1:0] phase_d;
    logic               mode_d;
    logic               valid_d;
    logic               done_d;
    logic               busy_d;

`ifdef SINCOS_PHASE_IQ_EN
    // The pair order fixes the cosine select, so the external select is not used.
    logic unused_mode_cos;
    assign unused_mode_cos = mode_cos_i;
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        counted_d  = counted_q;
        cos_beat_d = cos_beat_q;
        phase_d    = phase_o;
        mode_d     = mode_cos_o;
        valid_d    = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    acc_d      = phase_ofs_i;
                    cnt_d      = burst_len_i;
                    counted_d  = (burst_len_i != '0);
                    cos_beat_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (stop_i) begin
                    cos_beat_d = 1'b0;
                    state_d    = IDLE;
                end else if (counted_q && (cnt_q == '0)) begin
                    // Last sample is already on the outputs; finish regardless of hold.
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (!hold_i) begin
                    phase_d = acc_q;
                    valid_d = 1'b1;
`ifdef SINCOS_PHASE_IQ_EN
                    mode_d = cos_beat_q;
                    if (cos_beat_q) begin
                        acc_d      = acc_q + freq_word_i;
                        cos_beat_d = 1'b0;
                        if (counted_q) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end else begin
                        cos_beat_d = 1'b1;
                    end
`else
                    mode_d = mode_cos_i;
                    acc_d  = acc_q + freq_word_i;
                    if (counted_q) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            counted_q  <= 1'b0;
            cos_beat_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            counted_q  <= counted_d;
            cos_beat_q <= cos_beat_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_o    <= '0;
            mode_cos_o <= 1'b0;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            phase_o    <= phase_d;
            mode_cos_o <= mode_d;
            valid_o    <= valid_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
        end
    end

endmodule
